piso_stream: RTL and testbench
==============================

# piso_stream

Parametrised parallel-in/serial-out serializer with a valid/ready handshake on both sides. A word of WIDTH bits is accepted on the parallel side and emitted as WIDTH/LANES beats of LANES bits, MSB-first or LSB-first per word. A one-word holding buffer allows back-to-back words without bubbles. The block replaces the single-bit, free-running PISO wherever a downstream serial consumer can apply backpressure.

## Interface
- WIDTH, 8, parallel word width; WIDTH % LANES == 0 is required (elaboration-time assertion).
- LANES, 1, bits emitted per beat; BEATS = WIDTH/LANES; 1 <= LANES <= WIDTH.
- clk  input  1  single clock; all state updates on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  a parallel word is offered.
- in_ready  output  1  the block can take a word this cycle.
- in_data  input  WIDTH  parallel word.
- in_lsb_first  input  1  serialization order for this word (0 = MSB-first); captured with the word.
- ser_valid  output  1  ser_data holds a valid beat.
- ser_ready  input  1  downstream accepts the beat.
- ser_data  output  LANES  current beat.
- ser_last  output  1  current beat is the final beat of its word.
- busy  output  1  shifter or holding buffer occupied.

## Operation
- State:
  - shifter register `sh` with its order bit.
  - beat counter `cnt` (0..BEATS-1, width $clog2(BEATS) with a minimum of 1).
  - `active` flag.
  - holding register `hold` with `hold_full` and its order bit.
- Two-state FSM: IDLE (`active`=0) and SHIFT (`active`=1).
- Handshake rules:
  - in_ready = !hold_full.
  - A word is accepted when in_valid && in_ready.
  - A beat is accepted when ser_valid && ser_ready.
- ser_valid = `active`.
- ser_data:
  - MSB-first: `sh`[WIDTH-1 -: LANES].
  - LSB-first: `sh`[LANES-1:0].
- ser_last = `active` && `cnt` == BEATS-1.
- On an accepted non-last beat:
  - MSB-first shifts `sh` left by LANES; LSB-first shifts it right by LANES. Vacated bits fill with 0.
  - `cnt` increments.
- The shifter is free when `active`=0, or when the last beat is accepted this cycle.
- Load priority when the shifter is free:
  1. If `hold_full`: `sh` <= `hold`, `hold_full` <= 0, `cnt` <= 0, `active` <= 1.
  2. Else, if a word is accepted: it loads straight into `sh`, `cnt` <= 0, `active` <= 1.
  3. Else: `active` <= 0 (SHIFT -> IDLE).
- A word accepted while the shifter is not free goes to `hold`, and `hold_full` <= 1.
- In case 1 no word is accepted that cycle, because in_ready was 0.
- ser_data, ser_last and `sh` must not change while ser_valid && !ser_ready (stable-under-backpressure rule).
- busy = `active` || `hold_full`.
- Reset values: in_ready=1, ser_valid=0, ser_data=0, ser_last=0, busy=0; `sh`, `hold`, `cnt` and both order bits = 0.

## Timing
- Latency: a word accepted at edge N presents its first beat during the cycle after N.
- Throughput: with in_valid and ser_ready held high, one beat per cycle and no idle cycle between words.
- Sustained input, in_ready pattern:
  - It drops for BEATS-1 cycles per word once the holding buffer fills.
  - For BEATS=1 it stays high.
- Simultaneous events in one cycle (last beat accepted, `hold_full`=0, word accepted): the new word goes directly to the shifter, never through `hold`.
- BEATS=1: every beat has ser_last=1, and `cnt` stays 0.
- Reset asserted mid-word: all state clears immediately (asynchronously), and the partial word and any held word are discarded.

## Structure
- Shared package `piso_pkg`:
  - typedef enum for the IDLE/SHIFT states.
  - function `beat_cnt_w(width, lanes)` returning the counter width.
  - localparam for the default WIDTH/LANES.
- One sub-module, `piso_hold_buf`: the one-entry holding register, holding the data, the order bit and `hold_full`, with push/pop ports. The top level holds the shifter, counter and FSM.

## Test plan
- Reset: hold rst_n=0 for 2 cycles, then release -> in_ready=1, ser_valid=0, ser_last=0, busy=0. Check this both during and after reset.
- WIDTH=8, LANES=1, in_data=8'hD5, MSB-first, ser_ready=1 -> beats 1,1,0,1,0,1,0,1; ser_last only on the 8th; ser_valid drops on the next cycle.
- Same word with in_lsb_first=1 -> beats 1,0,1,0,1,0,1,1.
- WIDTH=8, LANES=2, 8'hD5 then 8'h3C offered back-to-back, both MSB-first:
  - beats 2'b11,01,01,01,00,11,11,00 on 8 consecutive cycles.
  - ser_last on beats 4 and 8.
  - in_ready low on the cycles when `hold` is full.
- Backpressure: drop ser_ready for 3 cycles mid-word -> ser_data and ser_last stay frozen, and no beat is lost or duplicated.
- Assert rst_n=0 after 3 beats with a second word held:
  - all outputs return to their reset values at once.
  - a fresh word 8'hA5 afterwards serializes as 1,0,1,0,0,1,0,1.

Source files
------------

// File: rtl/piso_pkg.sv
// piso_pkg: definitions shared by the piso_stream serializer and its holding buffer.
//   state_e    - two-state shifter FSM (IDLE: shifter empty, SHIFT: emitting beats)
//   beat_cnt_w - width of the beat counter for a given word width and lane count
//   DEFAULT_*  - default parallel word width and beat width
package piso_pkg;

    localparam int DEFAULT_WIDTH = 8;
    localparam int DEFAULT_LANES = 1;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_e;

    // Counter must index 0..BEATS-1; a single-beat word still gets a 1-bit counter.
    function automatic int beat_cnt_w(input int width, input int lanes);
        int beats;
        beats = width / lanes;
        return (beats > 1) ? $clog2(beats) : 1;
    endfunction

endpackage

// File: rtl/piso_hold_buf.sv
// piso_hold_buf: one-entry holding register that parks a parallel word (and its
// serialization order) while the shifter is still busy with the previous word.
//   clk, rst_n     - clock, asynchronous active-low reset
//   push_i         - store data_i / lsb_first_i and mark the entry full
//   pop_i          - release the entry (caller reads data_o / lsb_first_o the same cycle)
//   data_i         - parallel word to park
//   lsb_first_i    - serialization order of that word
//   full_o         - entry occupied
//   data_o         - parked word
//   lsb_first_o    - parked word's order bit
module piso_hold_buf
    import piso_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             lsb_first_i,
    output logic             full_o,
    output logic [WIDTH-1:0] data_o,
    output logic             lsb_first_o
);

    logic             full_q;
    logic [WIDTH-1:0] data_q;
    logic             lsb_q;

    // Push only happens while empty and pop only while full, so they never coincide.
    // NOTE: state uses non-blocking assignments, and the data register is reset too
    // (a single word, cheap, and keeps outputs deterministic after reset).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_q <= 1'b0;
            data_q <= '0;
            lsb_q  <= 1'b0;
        end else if (push_i) begin
            full_q <= 1'b1;
            data_q <= data_i;
            lsb_q  <= lsb_first_i;
        end else if (pop_i) begin
            full_q <= 1'b0;
        end
    end

    assign full_o      = full_q;
    assign data_o      = data_q;
    assign lsb_first_o = lsb_q;

endmodule

// File: rtl/piso_stream.sv
// piso_stream: parallel-in / serial-out serializer with valid/ready on both sides.
// A WIDTH-bit word is emitted as WIDTH/LANES beats of LANES bits, MSB- or LSB-first
// per word; a one-word holding buffer lets back-to-back words stream without bubbles.
//   clk, rst_n    - clock, asynchronous active-low reset
//   in_valid      - parallel word offered
//   in_ready      - block can take a word this cycle (holding buffer empty)
//   in_data       - parallel word
//   in_lsb_first  - order for this word (0 = MSB-first), captured with the word
//   ser_valid     - ser_data holds a valid beat
//   ser_ready     - downstream accepts the beat
//   ser_data      - current beat
//   ser_last      - current beat is the last of its word
//   busy          - shifter or holding buffer occupied
module piso_stream
    import piso_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int LANES = DEFAULT_LANES
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_lsb_first,
    output logic             ser_valid,
    input  logic             ser_ready,
    output logic [LANES-1:0] ser_data,
    output logic             ser_last,
    output logic             busy
);

    if (LANES < 1 || LANES > WIDTH || (WIDTH % LANES) != 0) begin : g_param_check
        $error("piso_stream: LANES must be in 1..WIDTH and divide WIDTH");
    end

    localparam int               BEATS    = WIDTH / LANES;
    localparam int               CNT_W    = beat_cnt_w(WIDTH, LANES);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BEATS - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] sh_q, sh_d;
    logic             sh_lsb_q, sh_lsb_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             hold_full;
    logic [WIDTH-1:0] hold_data;
    logic             hold_lsb;
    logic             hold_push;
    logic             hold_pop;

    logic active;
    logic word_acc;
    logic beat_acc;
    logic last_beat;
    logic shifter_free;

    assign active       = (state_q == ST_SHIFT);
    assign word_acc     = in_valid && !hold_full;
    assign beat_acc     = active && ser_ready;
    assign last_beat    = (cnt_q == LAST_CNT);
    assign shifter_free = !active || (beat_acc && last_beat);

    piso_hold_buf #(
        .WIDTH(WIDTH)
    ) u_hold (
        .clk        (clk),
        .rst_n      (rst_n),
        .push_i     (hold_push),
        .pop_i      (hold_pop),
        .data_i     (in_data),
        .lsb_first_i(in_lsb_first),
        .full_o     (hold_full),
        .data_o     (hold_data),
        .lsb_first_o(hold_lsb)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            sh_q     <= '0;
            sh_lsb_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            sh_q     <= sh_d;
            sh_lsb_q <= sh_lsb_d;
            cnt_q    <= cnt_d;
        end
    end

    // NOTE: every signal written here gets a default first so no latch is inferred.
    always_comb begin
        state_d   = state_q;
        sh_d      = sh_q;
        sh_lsb_d  = sh_lsb_q;
        cnt_d     = cnt_q;
        hold_push = 1'b0;
        hold_pop  = 1'b0;

        if (shifter_free) begin
            // A parked word always wins; in_ready is low then, so nothing new arrives.
            if (hold_full) begin
                sh_d     = hold_data;
                sh_lsb_d = hold_lsb;
                cnt_d    = '0;
                state_d  = ST_SHIFT;
                hold_pop = 1'b1;
            end else if (word_acc) begin
                // Bypass the holding buffer when the shifter frees up this very cycle.
                sh_d     = in_data;
                sh_lsb_d = in_lsb_first;
                cnt_d    = '0;
                state_d  = ST_SHIFT;
            end else begin
                state_d  = ST_IDLE;
            end
        end else begin
            hold_push = word_acc;
            // Here beat_acc implies a non-last beat; sh only moves on acceptance,
            // which keeps ser_data stable under backpressure.
            if (beat_acc) begin
                sh_d  = sh_lsb_q ? (sh_q >> LANES) : (sh_q << LANES);
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    assign in_ready  = !hold_full;
    assign ser_valid = active;
    assign ser_data  = sh_lsb_q ? sh_q[LANES-1:0] : sh_q[WIDTH-1 -: LANES];
    assign ser_last  = active && last_beat;
    assign busy      = active || hold_full;

endmodule

// File: tb/tb_piso_stream.sv
// Self-checking bench for piso_stream. Two instances (LANES=1 and LANES=2, WIDTH=8)
// share clock and reset; sel chooses which one the stimulus drives. The reference
// model tracks words in flight and a queue of expected beats computed arithmetically.
module tb_piso_stream;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       sel;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_lsb;
    logic       ser_ready;

    logic       a_in_ready, a_ser_valid, a_ser_last, a_busy;
    logic [0:0] a_ser_data;
    logic       b_in_ready, b_ser_valid, b_ser_last, b_busy;
    logic [1:0] b_ser_data;

    logic       o_in_ready, o_valid, o_last, o_busy;
    logic [1:0] o_data;

    int tests_run = 0;
    int fails     = 0;

    int         outst;
    logic [2:0] exp_q[$];
    int         obs_beats[$];

    always #5 clk = ~clk;

    piso_stream #(.WIDTH(8), .LANES(1)) dut_a (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid && !sel),
        .in_ready    (a_in_ready),
        .in_data     (in_data),
        .in_lsb_first(in_lsb),
        .ser_valid   (a_ser_valid),
        .ser_ready   (ser_ready),
        .ser_data    (a_ser_data),
        .ser_last    (a_ser_last),
        .busy        (a_busy)
    );

    piso_stream #(.WIDTH(8), .LANES(2)) dut_b (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid && sel),
        .in_ready    (b_in_ready),
        .in_data     (in_data),
        .in_lsb_first(in_lsb),
        .ser_valid   (b_ser_valid),
        .ser_ready   (ser_ready),
        .ser_data    (b_ser_data),
        .ser_last    (b_ser_last),
        .busy        (b_busy)
    );

    always_comb begin
        if (sel) begin
            o_in_ready = b_in_ready;
            o_valid    = b_ser_valid;
            o_last     = b_ser_last;
            o_busy     = b_busy;
            o_data     = b_ser_data;
        end else begin
            o_in_ready = a_in_ready;
            o_valid    = a_ser_valid;
            o_last     = a_ser_last;
            o_busy     = a_busy;
            o_data     = {1'b0, a_ser_data};
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Expected beats for one word: beat k takes bit group k counted from the chosen end.
    task automatic model_push(input logic [7:0] d, input logic lsb);
        int l;
        int nb;
        int sh;
        l  = sel ? 2 : 1;
        nb = 8 / l;
        for (int k = 0; k < nb; k++) begin
            sh = lsb ? k * l : 8 - (k + 1) * l;
            exp_q.push_back({(k == nb - 1), 2'((d >> sh) & ((1 << l) - 1))});
        end
        outst++;
    endtask

    task automatic model_clear();
        outst = 0;
        exp_q.delete();
    endtask

    // One clock: check outputs at negedge, advance the model at posedge, return at posedge+1.
    task automatic cycle();
        bit         w_acc;
        bit         b_acc;
        logic [2:0] fr;
        @(negedge clk);
        check("ser_valid", o_valid, outst > 0);
        check("in_ready", o_in_ready, outst < 2);
        check("busy", o_busy, outst > 0);
        w_acc = in_valid && (outst < 2);
        b_acc = (outst > 0) && ser_ready;
        if (outst > 0) begin
            fr = exp_q[0];
            check("ser_data", o_data, fr[1:0]);
            check("ser_last", o_last, fr[2]);
        end
        if (b_acc) obs_beats.push_back(int'(o_data));
        @(posedge clk);
        if (b_acc) begin
            fr = exp_q.pop_front();
            if (fr[2]) outst--;
        end
        if (w_acc) model_push(in_data, in_lsb);
        #1;
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_a_in_ready"}, a_in_ready, 1);
        check({tag, "_a_ser_valid"}, a_ser_valid, 0);
        check({tag, "_a_ser_last"}, a_ser_last, 0);
        check({tag, "_a_ser_data"}, a_ser_data, 0);
        check({tag, "_a_busy"}, a_busy, 0);
        check({tag, "_b_in_ready"}, b_in_ready, 1);
        check({tag, "_b_ser_valid"}, b_ser_valid, 0);
        check({tag, "_b_ser_last"}, b_ser_last, 0);
        check({tag, "_b_ser_data"}, b_ser_data, 0);
        check({tag, "_b_busy"}, b_busy, 0);
    endtask

    task automatic check_beats(input string tag, input int n, input int exp[8]);
        check({tag, "_count"}, obs_beats.size(), n);
        for (int i = 0; i < n; i++) begin
            if (i < obs_beats.size()) check($sformatf("%s_beat%0d", tag, i), obs_beats[i], exp[i]);
        end
    endtask

    task automatic random_phase(input logic s, input int n);
        sel = s;
        for (int i = 0; i < n; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_data   = 8'($urandom);
            in_lsb    = 1'($urandom_range(0, 1));
            ser_ready = ($urandom_range(0, 3) != 0);
            cycle();
        end
        in_valid  = 1'b0;
        ser_ready = 1'b1;
        for (int i = 0; i < 40 && outst > 0; i++) cycle();
        @(negedge clk);
        check("drain_busy", o_busy, 0);
        check("drain_ser_valid", o_valid, 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n     = 1'b0;
        sel       = 1'b0;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        in_lsb    = 1'b0;
        ser_ready = 1'b1;
        model_clear();

        // Reset held for two cycles, checked during and after.
        @(negedge clk);
        check_reset("rst_c1");
        @(negedge clk);
        check_reset("rst_c2");
        #1 rst_n = 1'b1;
        @(negedge clk);
        check_reset("post_rst");
        @(posedge clk);
        #1;

        // LANES=1, 8'hD5 MSB-first.
        sel = 1'b0;
        obs_beats.delete();
        in_valid = 1'b1; in_data = 8'hD5; in_lsb = 1'b0;
        cycle();
        in_valid = 1'b0;
        repeat (9) cycle();
        check_beats("d5_msb", 8, '{1, 1, 0, 1, 0, 1, 0, 1});

        // LANES=1, 8'hD5 LSB-first.
        obs_beats.delete();
        in_valid = 1'b1; in_data = 8'hD5; in_lsb = 1'b1;
        cycle();
        in_valid = 1'b0;
        repeat (9) cycle();
        check_beats("d5_lsb", 8, '{1, 0, 1, 0, 1, 0, 1, 1});

        // LANES=2, 8'hD5 and 8'h3C back-to-back, MSB-first.
        sel = 1'b1;
        obs_beats.delete();
        in_valid = 1'b1; in_data = 8'hD5; in_lsb = 1'b0;
        cycle();
        in_data = 8'h3C;
        cycle();
        in_valid = 1'b0;
        repeat (9) cycle();
        check_beats("b2b", 8, '{3, 1, 1, 1, 0, 3, 3, 0});

        // LANES=2, 8'h9B with ser_ready low for 3 cycles after the first beat.
        obs_beats.delete();
        in_valid = 1'b1; in_data = 8'h9B; in_lsb = 1'b0;
        cycle();
        in_valid = 1'b0;
        cycle();
        ser_ready = 1'b0;
        repeat (3) cycle();
        ser_ready = 1'b1;
        repeat (4) cycle();
        check_beats("bp", 4, '{2, 1, 2, 3, 0, 0, 0, 0});

        // LANES=1: reset after 3 beats with a second word held.
        sel = 1'b0;
        obs_beats.delete();
        in_valid = 1'b1; in_data = 8'hF0; in_lsb = 1'b0;
        cycle();
        in_data = 8'h0F;
        cycle();
        in_valid = 1'b0;
        cycle();
        cycle();
        check("mid_beats_before_rst", obs_beats.size(), 3);
        check("mid_hold_full", a_in_ready, 0);
        rst_n = 1'b0;
        #1;
        check_reset("rst_mid_now");
        model_clear();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset("rst_mid_held");
        #1 rst_n = 1'b1;
        cycle();
        obs_beats.delete();
        in_valid = 1'b1; in_data = 8'hA5; in_lsb = 1'b0;
        cycle();
        in_valid = 1'b0;
        repeat (9) cycle();
        check_beats("a5_after_rst", 8, '{1, 0, 1, 0, 0, 1, 0, 1});

        // Randomized traffic on both widths against the model.
        random_phase(1'b0, 300);
        random_phase(1'b1, 300);

        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
